// File: rtl/step_pulse_gen_pkg.sv
// Shared constants and the state encoding for the step/direction pulse generator.
// Timing defaults are derived from the 50 MHz system clock.
package step_pulse_gen_pkg;

    localparam int CLK_HZ      = 50_000_000;
    localparam int CLKS_PER_US = CLK_HZ / 1_000_000;

    localparam int DEF_PULSE_W    = CLKS_PER_US;      // 1 us step high time
    localparam int DEF_DIR_SETUP  = 5 * CLKS_PER_US;  // 5 us dir-to-step setup
    localparam int DEF_MIN_PERIOD = 2 * CLKS_PER_US;  // 2 us fastest step rate

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_HIGH,
        ST_LOW
    } state_e;

endpackage

// File: rtl/step_pulse_gen_if.sv
// Tracking-controller <-> step generator signal bundle.
// The controller side is the master; the pulse generator is the slave.
interface step_pulse_gen_if #(
    parameter int WIDTH_WORK = 16,
    parameter int POS_WIDTH  = 32
);
    logic                         drv_enable_SM;
    logic                         drv_dir;
    logic        [WIDTH_WORK-1:0] n;
    logic                         drv_step;
    logic                         dir_out;
    logic                         busy;
    logic signed [POS_WIDTH-1:0]  position;
    logic                         clamped;

    modport master (
        output drv_enable_SM, drv_dir, n,
        input  drv_step, dir_out, busy, position, clamped
    );

    modport slave (
        input  drv_enable_SM, drv_dir, n,
        output drv_step, dir_out, busy, position, clamped
    );
endinterface

// File: rtl/step_pos_counter.sv
// Signed step counter: +1 per step strobe when dir=1, -1 otherwise.
// Wraps modulo 2^POS_WIDTH.
module step_pos_counter #(
    parameter int POS_WIDTH = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        step,
    input  logic                        dir,
    output logic signed [POS_WIDTH-1:0] count
);
    localparam logic signed [POS_WIDTH-1:0] ONE = POS_WIDTH'(1);

    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (step) begin
            count <= dir ? count + ONE : count - ONE;
        end
    end
endmodule

// File: rtl/step_pulse_gen.sv
// Step/direction pulse generator: fixed-width step pulses at a latched period,
// with a direction setup gap inserted whenever the requested direction changes.
module step_pulse_gen
    import step_pulse_gen_pkg::*;
#(
    parameter int WIDTH_WORK = 16,
    parameter int POS_WIDTH  = 32,
    parameter int PULSE_W    = DEF_PULSE_W,
    parameter int DIR_SETUP  = DEF_DIR_SETUP,
    parameter int MIN_PERIOD = DEF_MIN_PERIOD   // must exceed PULSE_W
) (
    input logic             clk,
    input logic             rst,
    step_pulse_gen_if.slave bus
);
    localparam int SETUP_W = (DIR_SETUP > 1) ? $clog2(DIR_SETUP) : 1;

    localparam logic [WIDTH_WORK-1:0] PULSE_LAST = WIDTH_WORK'(PULSE_W - 1);
    localparam logic [WIDTH_WORK-1:0] MIN_P      = WIDTH_WORK'(MIN_PERIOD);
    localparam logic [WIDTH_WORK-1:0] W_ONE      = WIDTH_WORK'(1);
    localparam logic [SETUP_W-1:0]    SETUP_LAST = SETUP_W'(DIR_SETUP - 1);
    localparam logic [SETUP_W-1:0]    S_ONE      = SETUP_W'(1);

    state_e                 state, state_next;
    logic                   start_pulse, enter_setup;
    logic                   n_zero;
    logic [WIDTH_WORK-1:0]  period_cnt;   // clocks since the current rising edge
    logic [WIDTH_WORK-1:0]  p_eff;
    logic [SETUP_W-1:0]     setup_cnt;
    logic                   drv_step_q, dir_out_q, clamped_q;
    logic signed [POS_WIDTH-1:0] position;

    assign n_zero = (bus.n == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    // NOTE: every output of this block gets a default first, so no latches are inferred.
    always_comb begin
        state_next  = state;
        start_pulse = 1'b0;
        enter_setup = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (bus.drv_enable_SM && !n_zero) begin
                    if (bus.drv_dir != dir_out_q) enter_setup = 1'b1;
                    else                          start_pulse = 1'b1;
                end
            end
            ST_SETUP: begin
                if (!bus.drv_enable_SM)          state_next  = ST_IDLE;
                else if (setup_cnt == SETUP_LAST) start_pulse = 1'b1;
            end
            ST_HIGH: begin
                if (period_cnt == PULSE_LAST) state_next = ST_LOW;
            end
            ST_LOW: begin
                if (period_cnt == p_eff - W_ONE) begin
                    if (!bus.drv_enable_SM || n_zero)   state_next  = ST_IDLE;
                    else if (bus.drv_dir != dir_out_q) enter_setup = 1'b1;
                    else                               start_pulse = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
        if (start_pulse) state_next = ST_HIGH;
        if (enter_setup) state_next = ST_SETUP;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drv_step_q <= 1'b0;
            dir_out_q  <= 1'b0;
            clamped_q  <= 1'b0;
            period_cnt <= '0;
            p_eff      <= '0;
            setup_cnt  <= '0;
        end else begin
            drv_step_q <= (state_next == ST_HIGH);
            clamped_q  <= start_pulse && !n_zero && (bus.n < MIN_P);

            // The period is only ever sampled at a pulse start.
            if (start_pulse) begin
                p_eff      <= (bus.n < MIN_P) ? MIN_P : bus.n;
                period_cnt <= '0;
            end else if (state == ST_HIGH || state == ST_LOW) begin
                period_cnt <= period_cnt + W_ONE;
            end

            if (enter_setup) begin
                dir_out_q <= bus.drv_dir;
                setup_cnt <= '0;
            end else if (state == ST_SETUP) begin
                setup_cnt <= setup_cnt + S_ONE;
            end
        end
    end

    step_pos_counter #(
        .POS_WIDTH (POS_WIDTH)
    ) u_pos (
        .clk   (clk),
        .rst   (rst),
        .step  (start_pulse),
        .dir   (dir_out_q),
        .count (position)
    );

    assign bus.drv_step = drv_step_q;
    assign bus.dir_out  = dir_out_q;
    assign bus.clamped  = clamped_q;
    assign bus.position = position;
    assign bus.busy     = (state != ST_IDLE);
endmodule

// File: tb/tb_step_pulse_gen.sv
// Directed bench for step_pulse_gen: default 50 MHz instance plus a narrow
// instance (4-bit position, short timings) used to exercise signed wrap-around.
module tb_step_pulse_gen;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    step_pulse_gen_if #(.WIDTH_WORK(16), .POS_WIDTH(32)) bus ();
    step_pulse_gen_if #(.WIDTH_WORK(8),  .POS_WIDTH(4))  sb ();

    step_pulse_gen u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    step_pulse_gen #(
        .WIDTH_WORK (8),
        .POS_WIDTH  (4),
        .PULSE_W    (2),
        .DIR_SETUP  (3),
        .MIN_PERIOD (5)
    ) u_small (
        .clk (clk),
        .rst (rst),
        .bus (sb)
    );

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Waits for drv_step of the main instance to change to `level`; returns the cycle.
    task automatic wait_edge(input logic level, input int budget, output int at);
        logic prev;
        prev = bus.drv_step;
        at   = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bus.drv_step === level && prev !== level) begin
                at = cyc;
                return;
            end
            prev = bus.drv_step;
        end
        checks++; errors++;
        $display("FAIL edge_timeout: drv_step never reached %b within %0d cycles", level, budget);
    endtask

    task automatic test_reset();
        bus.drv_enable_SM = 1'b0; bus.drv_dir = 1'b0; bus.n = 16'd200;
        sb.drv_enable_SM  = 1'b0; sb.drv_dir  = 1'b0; sb.n  = 8'd0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (bus.drv_step !== 1'b0) begin errors++; $display("FAIL reset_step: got %b want 0", bus.drv_step); end
        checks++; if (bus.dir_out  !== 1'b0) begin errors++; $display("FAIL reset_dir: got %b want 0", bus.dir_out); end
        checks++; if (bus.busy     !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        checks++; if (bus.clamped  !== 1'b0) begin errors++; $display("FAIL reset_clamped: got %b want 0", bus.clamped); end
        checks++; if (bus.position !== 0)    begin errors++; $display("FAIL reset_position: got %0d want 0", bus.position); end
        rst = 1'b0;
    endtask

    task automatic test_reverse_steps(output int r2);
        int c, r0, r1, f0;
        c = cyc;
        bus.drv_enable_SM = 1'b1;
        wait_edge(1'b1, 5, r0);
        checks++; if (r0 - c != 1) begin errors++; $display("FAIL first_rise_latency: got %0d want 1", r0 - c); end
        checks++; if (bus.dir_out !== 1'b0 || bus.busy !== 1'b1) begin errors++; $display("FAIL first_no_setup: dir_out %b busy %b want 0 1", bus.dir_out, bus.busy); end
        checks++; if (bus.position !== -1) begin errors++; $display("FAIL rev_pos1: got %0d want -1", bus.position); end
        wait_edge(1'b0, 60, f0);
        checks++; if (f0 - r0 != 50) begin errors++; $display("FAIL pulse_width: got %0d want 50", f0 - r0); end
        wait_edge(1'b1, 250, r1);
        checks++; if (r1 - r0 != 200) begin errors++; $display("FAIL period_200a: got %0d want 200", r1 - r0); end
        checks++; if (bus.position !== -2) begin errors++; $display("FAIL rev_pos2: got %0d want -2", bus.position); end
        wait_edge(1'b1, 250, r2);
        checks++; if (r2 - r1 != 200) begin errors++; $display("FAIL period_200b: got %0d want 200", r2 - r1); end
        checks++; if (bus.position !== -3) begin errors++; $display("FAIL rev_pos3: got %0d want -3", bus.position); end
    endtask

    task automatic test_dir_change(input int r2, output int r3);
        int d;
        repeat (100) @(negedge clk);
        bus.drv_dir = 1'b1;
        repeat (50) @(negedge clk);
        checks++; if (bus.dir_out !== 1'b0) begin errors++; $display("FAIL dir_hold_mid_period: got %b want 0", bus.dir_out); end
        d = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.dir_out === 1'b1) begin d = cyc; break; end
        end
        checks++; if (d - r2 != 200) begin errors++; $display("FAIL dir_update_time: got %0d want 200", d - r2); end
        checks++; if (bus.drv_step !== 1'b0 || bus.busy !== 1'b1) begin errors++; $display("FAIL setup_state: step %b busy %b want 0 1", bus.drv_step, bus.busy); end
        wait_edge(1'b1, 300, r3);
        checks++; if (r3 - d != 250) begin errors++; $display("FAIL setup_len: got %0d want 250", r3 - d); end
        checks++; if (bus.position !== -2) begin errors++; $display("FAIL fwd_step_pos: got %0d want -2", bus.position); end
    endtask

    task automatic test_clamp(input int r3, output int r5);
        int r4;
        bus.n = 16'd30;
        wait_edge(1'b1, 250, r4);
        checks++; if (r4 - r3 != 200) begin errors++; $display("FAIL old_period_kept: got %0d want 200", r4 - r3); end
        checks++; if (bus.clamped !== 1'b1) begin errors++; $display("FAIL clamp_pulse_a: got %b want 1", bus.clamped); end
        @(negedge clk);
        checks++; if (bus.clamped !== 1'b0) begin errors++; $display("FAIL clamp_one_cycle: got %b want 0", bus.clamped); end
        wait_edge(1'b1, 150, r5);
        checks++; if (r5 - r4 != 100) begin errors++; $display("FAIL min_period: got %0d want 100", r5 - r4); end
        checks++; if (bus.clamped !== 1'b1) begin errors++; $display("FAIL clamp_pulse_b: got %b want 1", bus.clamped); end
        checks++; if (bus.position !== 0) begin errors++; $display("FAIL clamp_pos: got %0d want 0", bus.position); end
    endtask

    task automatic test_n_change(input int r5, output int r8);
        int r6, r7;
        bus.n = 16'd200;
        wait_edge(1'b1, 150, r6);
        checks++; if (r6 - r5 != 100) begin errors++; $display("FAIL clamped_period_kept: got %0d want 100", r6 - r5); end
        checks++; if (bus.clamped !== 1'b0) begin errors++; $display("FAIL no_clamp: got %b want 0", bus.clamped); end
        bus.n = 16'd400;
        wait_edge(1'b1, 250, r7);
        checks++; if (r7 - r6 != 200) begin errors++; $display("FAIL n_change_current: got %0d want 200", r7 - r6); end
        wait_edge(1'b1, 450, r8);
        checks++; if (r8 - r7 != 400) begin errors++; $display("FAIL n_change_next: got %0d want 400", r8 - r7); end
        checks++; if (bus.position !== 3) begin errors++; $display("FAIL n_change_pos: got %0d want 3", bus.position); end
    endtask

    task automatic test_enable_drop(input int r8);
        int r9, f9, b;
        bus.n = 16'd200;
        wait_edge(1'b1, 450, r9);
        checks++; if (r9 - r8 != 400) begin errors++; $display("FAIL period_400: got %0d want 400", r9 - r8); end
        repeat (10) @(negedge clk);
        bus.drv_enable_SM = 1'b0;
        wait_edge(1'b0, 60, f9);
        checks++; if (f9 - r9 != 50) begin errors++; $display("FAIL pulse_not_truncated: got %0d want 50", f9 - r9); end
        b = -1;
        for (int i = 0; i < 250; i++) begin
            @(negedge clk);
            if (bus.busy === 1'b0) begin b = cyc; break; end
        end
        checks++; if (b - r9 != 200) begin errors++; $display("FAIL idle_after_period: got %0d want 200", b - r9); end
        repeat (20) @(negedge clk);
        checks++; if (bus.busy !== 1'b0 || bus.drv_step !== 1'b0) begin errors++; $display("FAIL stays_idle: busy %b step %b want 0 0", bus.busy, bus.drv_step); end
        checks++; if (bus.position !== 4) begin errors++; $display("FAIL drop_pos: got %0d want 4", bus.position); end
    endtask

    task automatic test_setup_toggle_abort();
        int c, r, d, rises;
        logic prev;
        c = cyc;
        bus.drv_dir = 1'b0;
        bus.drv_enable_SM = 1'b1;
        @(negedge clk);
        checks++; if (bus.busy !== 1'b1 || bus.dir_out !== 1'b0) begin errors++; $display("FAIL setup_entry: busy %b dir_out %b want 1 0", bus.busy, bus.dir_out); end
        repeat (9) @(negedge clk);
        bus.drv_dir = 1'b1;
        wait_edge(1'b1, 300, r);
        checks++; if (r - c != 251) begin errors++; $display("FAIL setup_despite_toggle: got %0d want 251", r - c); end
        checks++; if (bus.dir_out !== 1'b0 || bus.position !== 3) begin errors++; $display("FAIL setup_dir_kept: dir_out %b pos %0d want 0 3", bus.dir_out, bus.position); end
        d = -1;
        for (int i = 0; i < 250; i++) begin
            @(negedge clk);
            if (bus.dir_out === 1'b1) begin d = cyc; break; end
        end
        checks++; if (d - r != 200) begin errors++; $display("FAIL resetup_time: got %0d want 200", d - r); end
        bus.drv_enable_SM = 1'b0;
        @(negedge clk);
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL setup_abort: busy got %b want 0", bus.busy); end
        rises = 0;
        prev  = bus.drv_step;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (bus.drv_step === 1'b1 && prev !== 1'b1) rises++;
            prev = bus.drv_step;
        end
        checks++; if (rises != 0 || bus.position !== 3) begin errors++; $display("FAIL abort_no_pulse: rises %0d pos %0d want 0 3", rises, bus.position); end
    endtask

    task automatic test_pos_wrap();
        bit found;
        sb.n = 8'd5;
        sb.drv_dir = 1'b1;
        sb.drv_enable_SM = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (sb.position === 4'sd7) begin found = 1'b1; break; end
        end
        checks++; if (!found) begin errors++; $display("FAIL wrap_reach_max: got %0d want 7", sb.position); end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (sb.position !== 4'sd7) break;
        end
        checks++; if (sb.position !== 4'b1000) begin errors++; $display("FAIL pos_wrap: got %b want 1000", sb.position); end
        sb.drv_enable_SM = 1'b0;
    endtask

    task automatic test_reset_mid_high();
        int c, r;
        c = cyc;
        bus.drv_enable_SM = 1'b1;
        wait_edge(1'b1, 5, r);
        checks++; if (r - c != 1 || bus.position !== 4) begin errors++; $display("FAIL pre_reset_pulse: lat %0d pos %0d want 1 4", r - c, bus.position); end
        repeat (10) @(negedge clk);
        #3 rst = 1'b1;
        #1;
        checks++; if (bus.drv_step !== 1'b0) begin errors++; $display("FAIL async_reset_step: got %b want 0", bus.drv_step); end
        checks++; if (bus.position !== 0 || bus.busy !== 1'b0 || bus.dir_out !== 1'b0) begin errors++; $display("FAIL async_reset_state: pos %0d busy %b dir %b want 0 0 0", bus.position, bus.busy, bus.dir_out); end
        @(negedge clk);
        bus.drv_enable_SM = 1'b0;
        rst = 1'b0;
        repeat (5) @(negedge clk);
        checks++; if (bus.drv_step !== 1'b0 || bus.busy !== 1'b0 || bus.position !== 0) begin errors++; $display("FAIL post_reset: step %b busy %b pos %0d want 0 0 0", bus.drv_step, bus.busy, bus.position); end
    endtask

    task automatic test_n_zero();
        bus.n = 16'd0;
        bus.drv_enable_SM = 1'b1;
        repeat (10) @(negedge clk);
        checks++; if (bus.busy !== 1'b0 || bus.drv_step !== 1'b0) begin errors++; $display("FAIL n_zero_idle: busy %b step %b want 0 0", bus.busy, bus.drv_step); end
        bus.drv_enable_SM = 1'b0;
    endtask

    initial begin
        int r2, r3, r5, r8;
        test_reset();
        test_reverse_steps(r2);
        test_dir_change(r2, r3);
        test_clamp(r3, r5);
        test_n_change(r5, r8);
        test_enable_drop(r8);
        test_setup_toggle_abort();
        test_pos_wrap();
        test_reset_mid_high();
        test_n_zero();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
